// File: rtl/div71x16_seq.sv
// Sequential radix-2 restoring divider: 71-bit dividend / 16-bit divisor ->
// 55-bit quotient and 16-bit remainder, one quotient bit per enabled clock.
module div71x16_seq #(
    parameter int ASIZE = 55,
    parameter int BSIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   start,
    input  logic [ASIZE+BSIZE-1:0] dividend,
    input  logic [BSIZE-1:0]       divisor,
    output logic                   ready,
    output logic                   valid,
    output logic [ASIZE-1:0]       quotient,
    output logic [BSIZE-1:0]       remainder,
    output logic                   div_by_zero,
    output logic                   overflow
);
    localparam int DSIZE = ASIZE + BSIZE;
    localparam int CW    = $clog2(ASIZE + 1);

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t           r_state, w_next;
    logic [BSIZE-1:0] r_div;
    logic [BSIZE-1:0] r_rem;
    logic [ASIZE-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_valid, r_dbz, r_ovf;
    logic [ASIZE-1:0] r_quot;
    logic [BSIZE-1:0] r_remo;

    logic             w_accept, w_dbz, w_ovf, w_last, w_qbit;
    logic [BSIZE:0]   w_trial, w_diff;
    logic [BSIZE-1:0] w_rem_nx;
    logic [ASIZE-1:0] w_sh_nx;

    assign w_accept = (r_state == S_IDLE) && ce && start;
    assign w_dbz    = (divisor == '0);
    // Upper dividend half >= divisor means the quotient needs more than ASIZE bits.
    assign w_ovf    = (dividend[DSIZE-1:ASIZE] >= divisor);
    assign w_last   = (r_cnt == CW'(ASIZE - 1));

    // Partial remainder stays below the divisor, so BSIZE bits hold it between
    // iterations; the shifted trial value and its difference need BSIZE+1.
    assign w_trial  = {r_rem, r_sh[ASIZE-1]};
    assign w_diff   = w_trial - {1'b0, r_div};
    assign w_qbit   = ~w_diff[BSIZE];
    assign w_rem_nx = w_qbit ? w_diff[BSIZE-1:0] : w_trial[BSIZE-1:0];
    assign w_sh_nx  = {r_sh[ASIZE-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !w_dbz && !w_ovf) w_next = S_CALC;
            S_CALC: if (ce && w_last)                 w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_rem   <= '0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_div <= divisor;
                if (w_dbz || w_ovf) begin
                    r_quot  <= '1;
                    r_remo  <= '0;
                    r_dbz   <= w_dbz;
                    r_ovf   <= ~w_dbz;
                    r_valid <= 1'b1;
                end else begin
                    r_rem <= dividend[DSIZE-1:ASIZE];
                    r_sh  <= dividend[ASIZE-1:0];
                    r_cnt <= '0;
                end
            end else if (r_state == S_CALC && ce) begin
                r_rem <= w_rem_nx;
                r_sh  <= w_sh_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quot  <= w_sh_nx;
                    r_remo  <= w_rem_nx;
                    r_dbz   <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign valid       = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_div71x16_seq.sv
// Randomized self-checking bench for div71x16_seq against an arithmetic model.
module tb_div71x16_seq;
    logic        clk = 1'b0;
    logic        rst_n, ce, start;
    logic [70:0] dividend;
    logic [15:0] divisor;
    logic        ready, valid, div_by_zero, overflow;
    logic [54:0] quotient;
    logic [15:0] remainder;

    int checks = 0;
    int failures = 0;

    div71x16_seq dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .valid(valid), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide integer division with the special-case rules.
    task automatic model(input logic [70:0] a, input logic [15:0] b,
                         output logic [54:0] q, output logic [15:0] r,
                         output logic dz, output logic ov);
        logic [70:0] qq, rr;
        dz = 1'b0; ov = 1'b0; q = '1; r = '0;
        if (b == 16'd0) dz = 1'b1;
        else begin
            qq = a / {55'd0, b};
            rr = a % {55'd0, b};
            if (qq > {16'd0, {55{1'b1}}}) ov = 1'b1;
            else begin
                q = qq[54:0];
                r = rr[15:0];
            end
        end
    endtask

    // Called just after a negedge; returns just after the negedge where valid is seen.
    task automatic run_op(input string tag, input logic [70:0] a, input logic [15:0] b,
                          input logic [54:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat,
                          input bit ce_rand, input bit inject);
        int  en, cyc;
        bit  rdy_bad, injected;
        chk({tag, "_ready_pre"}, ready, 1);
        dividend = a; divisor = b; start = 1'b1; ce = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en = 0; cyc = 0; rdy_bad = 0; injected = 0;
        while (!valid && cyc < 2000) begin
            if (ready) rdy_bad = 1;
            ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ce) en++;
            if (inject && !injected && en >= 10) begin
                start = 1'b1; dividend = {$urandom, $urandom, 7'h5}; divisor = 16'd1;
                injected = 1;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; ce = 1'b1;
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_latency"}, en, elat);
        chk({tag, "_ready_calc_low"}, rdy_bad, 0);
        chk({tag, "_ready_at_valid"}, ready, 1);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        chk({tag, "_ovf"}, overflow, eov);
    endtask

    initial begin
        logic [70:0] a;
        logic [15:0] b, er;
        logic [54:0] eq;
        logic        edz, eov;
        int          vbad;

        rst_n = 1'b0; ce = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1000000_7", 71'd1000000, 16'd7, 55'd142857, 16'd1, 0, 0, 55, 0, 0);
        a = 71'h7FFFFFFFFFFFFF * 71'hFFFF + 71'hFFFE;
        run_op("tmax", a, 16'hFFFF, {55{1'b1}}, 16'hFFFE, 0, 0, 55, 0, 0);
        // Back-to-back: start issued in the valid cycle.
        run_op("tdiv0", 71'h12345, 16'd0, {55{1'b1}}, 16'd0, 1, 0, 0, 0, 0);
        run_op("tovf", 71'd1 << 70, 16'd1, {55{1'b1}}, 16'd0, 0, 1, 0, 0, 0);
        run_op("tce", 71'd12345678, 16'd100, 55'd123456, 16'd78, 0, 0, 55, 1, 1);

        // Valid must drop after one cycle even with ce low.
        ce = 1'b0;
        @(negedge clk);
        chk("valid_one_cycle_ce0", valid, 0);
        chk("hold_quot_ce0", quotient, 55'd123456);
        ce = 1'b1;

        for (int i = 0; i < 24; i++) begin
            b = 16'($urandom_range(0, 65535));
            if (i % 8 == 3) b = 16'd0;
            a[54:0]  = {$urandom, $urandom};
            a[70:55] = 16'($urandom);
            if (b != 0 && (i % 4) != 1) a[70:55] = a[70:55] % b;
            model(a, b, eq, er, edz, eov);
            run_op($sformatf("rnd%0d", i), a, b, eq, er, edz, eov,
                   (edz || eov) ? 0 : 55, (i % 3) == 0, (i % 5) == 2);
        end

        // Abort mid-operation with an asynchronous reset.
        dividend = 71'd999999; divisor = 16'd7; start = 1'b1; ce = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_abort_ready", ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vbad = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid) vbad++;
        end
        chk("abort_no_valid", vbad, 0);
        run_op("t999_10", 71'd999, 16'd10, 55'd99, 16'd9, 0, 0, 55, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
